// File: rtl/nes_spr_dma.sv
// Sprite (OAM) DMA: snoops a CPU write to DMA_REG_ADDR, then copies page {data,8'h00} to OAM_DATA_ADDR via the spr master port.
// Optional macro NES_SPR_DMA_ALIGN_EN inserts an ALIGN dummy cycle when HALT lands on an odd cycle.
module nes_spr_dma #(
    parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
    parameter logic [15:0] OAM_DATA_ADDR = 16'h2004
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [15:0] i_bus_addr,
    input  logic        i_bus_wn,
    input  logic [7:0]  i_bus_wdata,
    output logic        o_spr_req,
    input  logic        i_spr_gnt,
    output logic [15:0] o_spr_addr,
    output logic        o_spr_wn,
    output logic [7:0]  o_spr_wdata,
    input  logic [7:0]  i_spr_rdata,
    output logic        o_dma_busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HALT,
`ifdef NES_SPR_DMA_ALIGN_EN
        S_ALIGN,
`endif
        S_READ,
        S_WRITE
    } state_t;

    state_t      r_state, w_state;
    logic [7:0]  r_index, w_index;
    logic [7:0]  r_page,  w_page;
    logic [7:0]  r_wdata, w_wdata;
    logic [15:0] r_addr,  w_addr;
    logic        r_wn,    w_wn;
    logic        r_req,   w_req;
    logic        w_trig;

`ifdef NES_SPR_DMA_ALIGN_EN
    logic r_parity;

    // Free-running cycle parity, independent of the transfer state.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_parity <= 1'b0;
        else       r_parity <= ~r_parity;
    end
`endif

    assign w_trig = (i_bus_addr == DMA_REG_ADDR) && !i_bus_wn;

    always_comb begin
        w_state = r_state;
        w_index = r_index;
        w_page  = r_page;
        w_wdata = r_wdata;
        case (r_state)
            S_IDLE: begin
                if (w_trig) begin
                    w_page  = i_bus_wdata;
                    w_index = 8'h00;
                    w_state = S_HALT;
                end
            end
            S_HALT: begin
`ifdef NES_SPR_DMA_ALIGN_EN
                w_state = r_parity ? S_ALIGN : S_READ;
`else
                w_state = S_READ;
`endif
            end
`ifdef NES_SPR_DMA_ALIGN_EN
            S_ALIGN: w_state = S_READ;
`endif
            S_READ: begin
                if (i_spr_gnt) begin
                    w_wdata = i_spr_rdata;
                    w_state = S_WRITE;
                end
            end
            S_WRITE: begin
                if (i_spr_gnt) begin
                    w_index = r_index + 8'h01;
                    w_state = (r_index == 8'hFF) ? S_IDLE : S_READ;
                end
            end
            default: w_state = S_IDLE;
        endcase
    end

    // Bus outputs are decoded from the next state so they line up with the state register.
    always_comb begin
        w_req  = (w_state != S_IDLE);
        w_wn   = 1'b1;
        w_addr = 16'h0000;
        case (w_state)
            S_HALT:  w_addr = DMA_REG_ADDR;
`ifdef NES_SPR_DMA_ALIGN_EN
            S_ALIGN: w_addr = DMA_REG_ADDR;
`endif
            S_READ:  w_addr = {w_page, w_index};
            S_WRITE: begin
                w_addr = OAM_DATA_ADDR;
                w_wn   = 1'b0;
            end
            default: w_addr = 16'h0000;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_index <= 8'h00;
            r_page  <= 8'h00;
            r_wdata <= 8'h00;
            r_addr  <= 16'h0000;
            r_wn    <= 1'b1;
            r_req   <= 1'b0;
        end else begin
            r_state <= w_state;
            r_index <= w_index;
            r_page  <= w_page;
            r_wdata <= w_wdata;
            r_addr  <= w_addr;
            r_wn    <= w_wn;
            r_req   <= w_req;
        end
    end

    assign o_spr_req   = r_req;
    assign o_dma_busy  = r_req;
    assign o_spr_addr  = r_addr;
    assign o_spr_wn    = r_wn;
    assign o_spr_wdata = r_wdata;

endmodule
